// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path constants and the fetch FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_pkg;

  localparam int                XLEN         = 32;
  localparam logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0]       NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0

  // BOOT: one cycle to steer the PC register onto RESET_VECTOR.
  // FETCH: read issued at the live PC.
  // WAIT: read stalled by memory, address held in a register.
  // DISCARD: a redirect overtook an in-flight read; drain it and drop the data.
  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load, otherwise a bubble.
// Latency: 1 cycle from i_load to o_valid.
// Backpressure: i_stall holds every field; a flush always wins over a stall.
module if_id_reg #(
  parameter int          XLEN      = rv32_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;

  // Prioritised update; the PC field only moves when a real instruction lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_stall) begin
      r_pc    <= r_pc;
      r_instr <= r_instr;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch control: drives the IMEM read handshake and computes NEXTPC.
// Latency: fetched word reaches IF/ID on the edge after IMEM_BUSYWAIT is low.
// Backpressure: HAZARD_STALL or a busy memory holds the PC via NEXTPC=PC.
module if_fetch_stage #(
  parameter int             XLEN         = rv32_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = rv32_pkg::RESET_VECTOR,
  parameter logic [31:0]    NOP_INSTR    = rv32_pkg::NOP_INSTR
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] NEXTPC,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  input  logic            HAZARD_STALL,
  output logic            IMEM_READ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_BUSYWAIT,
  input  logic [31:0]     IMEM_INSTR,
  output logic [XLEN-1:0] IFID_PC,
  output logic [31:0]     IFID_INSTR,
  output logic            IFID_VALID,
  output logic            FETCH_STALL
);

  import rv32_pkg::*;

  localparam logic [XLEN-1:0] W_ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] W_FOUR       = {{(XLEN-3){1'b0}}, 3'd4};

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] w_req_addr;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_fetch_done;

  // In FETCH the request follows the live PC; once memory stalls, the
  // registered copy keeps the address stable even if PC is redirected.
  assign w_req_addr   = (r_state == FETCH) ? PC : r_req_addr;
  assign IMEM_READ    = (r_state != BOOT);
  assign IMEM_ADDR    = w_req_addr & W_ALIGN_MASK;
  assign w_fetch_done = ((r_state == FETCH) || (r_state == WAIT)) && !IMEM_BUSYWAIT;
  assign w_target     = BRANCH_TARGET & W_ALIGN_MASK;
  assign w_pc_plus4   = PC + W_FOUR;
  assign FETCH_STALL  = (r_state == WAIT) || (r_state == DISCARD) ||
                        (IMEM_READ && IMEM_BUSYWAIT);

  // State register plus capture of the request address when a read stalls.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= BOOT;
      r_req_addr <= RESET_VECTOR;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == FETCH) && IMEM_BUSYWAIT) begin
        r_req_addr <= PC;
      end
    end
  end

  // Next-state and NEXTPC selection; the PC register loads NEXTPC every edge.
  always_comb begin
    w_state_nxt = r_state;
    NEXTPC      = PC;

    case (r_state)
      BOOT:    w_state_nxt = FETCH;
      FETCH:   if (IMEM_BUSYWAIT) w_state_nxt = BRANCH_TAKEN ? DISCARD : WAIT;
      // A redirect only needs draining if the read is still outstanding;
      // a read finishing this cycle is simply flushed out of IF/ID.
      WAIT: begin
        if (IMEM_BUSYWAIT && BRANCH_TAKEN) w_state_nxt = DISCARD;
        else if (!IMEM_BUSYWAIT)          w_state_nxt = FETCH;
      end
      DISCARD: if (!IMEM_BUSYWAIT) w_state_nxt = FETCH;
      default: w_state_nxt = BOOT;
    endcase

    if (r_state == BOOT)                     NEXTPC = RESET_VECTOR;
    else if (BRANCH_TAKEN)                   NEXTPC = w_target;
    else if (HAZARD_STALL || !w_fetch_done)  NEXTPC = PC;
    else                                     NEXTPC = w_pc_plus4;
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_flush (BRANCH_TAKEN),
    .i_stall (HAZARD_STALL),
    .i_load  (w_fetch_done),
    .i_pc    (w_req_addr),
    .i_instr (IMEM_INSTR),
    .o_pc    (IFID_PC),
    .o_instr (IFID_INSTR),
    .o_valid (IFID_VALID)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an external PC register and a tagged memory.
// Latency: n/a.
// Backpressure: IMEM_BUSYWAIT and HAZARD_STALL are driven from the vector table.
module tb_if_fetch_stage;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] NEXTPC;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        HAZARD_STALL;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_INSTR;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_INSTR;
  logic        IFID_VALID;
  logic        FETCH_STALL;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .PC            (PC),
    .NEXTPC        (NEXTPC),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .HAZARD_STALL  (HAZARD_STALL),
    .IMEM_READ     (IMEM_READ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_INSTR    (IMEM_INSTR),
    .IFID_PC       (IFID_PC),
    .IFID_INSTR    (IFID_INSTR),
    .IFID_VALID    (IFID_VALID),
    .FETCH_STALL   (FETCH_STALL)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Memory returns a word tagged with its address so IF/ID contents are traceable.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction
  assign IMEM_INSTR = tag(IMEM_ADDR);

  // External PC register: loads NEXTPC every edge, settling 1 time unit later.
  logic [31:0] pc_sample;
  initial PC = 32'h0;
  always @(posedge CLOCK) begin
    pc_sample = NEXTPC;
    #1 PC = pc_sample;
  end

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        hs;
    logic        busy;
    logic [31:0] npc;
    logic        rd;
    logic [31:0] addr;
    logic        fst;
    logic        vld;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic hs,
                              input logic busy, input logic [31:0] npc, input logic rd,
                              input logic [31:0] addr, input logic fst, input logic vld,
                              input logic [31:0] ipc);
    vec_t v;
    v.br = br; v.tgt = tgt; v.hs = hs; v.busy = busy; v.npc = npc;
    v.rd = rd; v.addr = addr; v.fst = fst; v.vld = vld; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic hs, input logic busy);
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = tgt;
    HAZARD_STALL  = hs;
    IMEM_BUSYWAIT = busy;
  endtask

  task automatic next_cycle();
    @(posedge CLOCK);
    #2;
  endtask

  initial begin
    // Row n = values seen in the cycle after edge n (row 0 is the BOOT cycle).
    //             br tgt         hs busy npc          rd addr         fst vld ipc
    vecs[0]  = mk(0, 32'h0,      0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0);
    vecs[1]  = mk(0, 32'h0,      0, 0, 32'h4,        1, 32'h0,        0, 0, 32'h0);
    vecs[2]  = mk(0, 32'h0,      0, 0, 32'h8,        1, 32'h4,        0, 1, 32'h0);
    vecs[3]  = mk(0, 32'h0,      0, 1, 32'h8,        1, 32'h8,        1, 1, 32'h4);
    vecs[4]  = mk(0, 32'h0,      0, 1, 32'h8,        1, 32'h8,        1, 0, 32'h0);
    vecs[5]  = mk(0, 32'h0,      0, 1, 32'h8,        1, 32'h8,        1, 0, 32'h0);
    vecs[6]  = mk(0, 32'h0,      0, 0, 32'hC,        1, 32'h8,        1, 0, 32'h0);
    vecs[7]  = mk(0, 32'h0,      0, 0, 32'h10,       1, 32'hC,        0, 1, 32'h8);
    vecs[8]  = mk(1, 32'h100,    0, 0, 32'h100,      1, 32'h10,       0, 1, 32'hC);
    vecs[9]  = mk(0, 32'h0,      0, 0, 32'h104,      1, 32'h100,      0, 0, 32'h0);
    vecs[10] = mk(1, 32'h20,     0, 0, 32'h20,       1, 32'h104,      0, 1, 32'h100);
    vecs[11] = mk(0, 32'h0,      0, 1, 32'h20,       1, 32'h20,       1, 0, 32'h0);
    vecs[12] = mk(1, 32'h200,    0, 1, 32'h200,      1, 32'h20,       1, 0, 32'h0);
    vecs[13] = mk(0, 32'h0,      0, 1, 32'h200,      1, 32'h20,       1, 0, 32'h0);
    vecs[14] = mk(0, 32'h0,      0, 0, 32'h200,      1, 32'h20,       1, 0, 32'h0);
    vecs[15] = mk(0, 32'h0,      0, 0, 32'h204,      1, 32'h200,      0, 0, 32'h0);
    vecs[16] = mk(1, 32'h3C,     0, 0, 32'h3C,       1, 32'h204,      0, 1, 32'h200);
    vecs[17] = mk(0, 32'h0,      0, 0, 32'h40,       1, 32'h3C,       0, 0, 32'h0);
    vecs[18] = mk(0, 32'h0,      1, 0, 32'h40,       1, 32'h40,       0, 1, 32'h3C);
    vecs[19] = mk(0, 32'h0,      1, 0, 32'h40,       1, 32'h40,       0, 1, 32'h3C);
    vecs[20] = mk(0, 32'h0,      0, 0, 32'h44,       1, 32'h40,       0, 1, 32'h3C);
    vecs[21] = mk(0, 32'h0,      0, 0, 32'h48,       1, 32'h44,       0, 1, 32'h40);
    vecs[22] = mk(0, 32'h0,      0, 0, 32'h4C,       1, 32'h48,       0, 1, 32'h44);

    RESET = 1'b1;
    drive(0, 32'h0, 0, 0);
    #7;
    chk("reset IFID_VALID", {31'b0, IFID_VALID}, 32'h0);
    chk("reset IFID_INSTR", IFID_INSTR, NOP);
    chk("reset IFID_PC", IFID_PC, 32'h0);
    chk("reset IMEM_READ", {31'b0, IMEM_READ}, 32'h0);
    chk("reset NEXTPC", NEXTPC, 32'h0);
    RESET = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].br, vecs[i].tgt, vecs[i].hs, vecs[i].busy);
      @(negedge CLOCK);
      chk($sformatf("row%0d NEXTPC", i), NEXTPC, vecs[i].npc);
      chk($sformatf("row%0d IMEM_READ", i), {31'b0, IMEM_READ}, {31'b0, vecs[i].rd});
      if (vecs[i].rd) chk($sformatf("row%0d IMEM_ADDR", i), IMEM_ADDR, vecs[i].addr);
      chk($sformatf("row%0d FETCH_STALL", i), {31'b0, FETCH_STALL}, {31'b0, vecs[i].fst});
      chk($sformatf("row%0d IFID_VALID", i), {31'b0, IFID_VALID}, {31'b0, vecs[i].vld});
      chk($sformatf("row%0d IFID_INSTR", i), IFID_INSTR, vecs[i].vld ? tag(vecs[i].ipc) : NOP);
      if (vecs[i].vld) chk($sformatf("row%0d IFID_PC", i), IFID_PC, vecs[i].ipc);
      next_cycle();
    end

    // Misaligned redirect to the top word: low bits dropped.
    drive(1, 32'hFFFF_FFFF, 0, 0);
    @(negedge CLOCK);
    chk("misaligned target NEXTPC", NEXTPC, 32'hFFFF_FFFC);
    next_cycle();

    // Sequential fetch at the top of the address space wraps to zero.
    drive(0, 32'h0, 0, 0);
    @(negedge CLOCK);
    chk("top IMEM_ADDR", IMEM_ADDR, 32'hFFFF_FFFC);
    chk("wrap NEXTPC", NEXTPC, 32'h0);
    next_cycle();

    @(negedge CLOCK);
    chk("top IFID_PC", IFID_PC, 32'hFFFF_FFFC);
    chk("top IFID_INSTR", IFID_INSTR, tag(32'hFFFF_FFFC));
    chk("after wrap NEXTPC", NEXTPC, 32'h4);
    next_cycle();

    // Stall plus busy memory: PC held, IF/ID keeps the word from address 0.
    drive(0, 32'h0, 1, 1);
    @(negedge CLOCK);
    chk("stall+busy NEXTPC", NEXTPC, 32'h4);
    chk("stall+busy FETCH_STALL", {31'b0, FETCH_STALL}, 32'h1);
    chk("stall+busy IFID_PC", IFID_PC, 32'h0);
    next_cycle();

    // Now in WAIT on 0x4; assert reset between edges.
    @(negedge CLOCK);
    chk("wait IMEM_READ", {31'b0, IMEM_READ}, 32'h1);
    chk("wait IMEM_ADDR", IMEM_ADDR, 32'h4);
    chk("wait IFID_INSTR", IFID_INSTR, tag(32'h0));
    #1 RESET = 1'b1;
    #1;
    chk("async reset IMEM_READ", {31'b0, IMEM_READ}, 32'h0);
    chk("async reset IFID_INSTR", IFID_INSTR, NOP);
    chk("async reset IFID_VALID", {31'b0, IFID_VALID}, 32'h0);
    chk("async reset NEXTPC", NEXTPC, 32'h0);
    chk("async reset FETCH_STALL", {31'b0, FETCH_STALL}, 32'h0);
    #1 RESET = 1'b0;
    drive(0, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch control sitting directly downstream of the PC register. It consumes the current PC, drives the instruction-memory read handshake, and computes NEXTPC back into the PC register.
- Owns the IF/ID pipeline register.
- The PC register loads unconditionally every clock, so all hold, redirect and flush behaviour is expressed through NEXTPC and the IF/ID register.

Parameters:
- XLEN, 32, datapath/address width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- PC  in  XLEN  current PC from PC register (settles #1 after CLOCK edge)
- NEXTPC  out  XLEN  value PC register loads at next CLOCK edge
- BRANCH_TAKEN  in  1  redirect from EX stage, valid in current cycle
- BRANCH_TARGET  in  XLEN  redirect address
- HAZARD_STALL  in  1  load-use stall from ID; hold IF/ID and PC
- IMEM_READ  out  1  instruction-memory read request
- IMEM_ADDR  out  XLEN  fetch address, word-aligned
- IMEM_BUSYWAIT  in  1  memory busy; data invalid while high
- IMEM_INSTR  in  32  returned instruction, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
- IFID_PC  out  XLEN  PC of instruction in IF/ID
- IFID_INSTR  out  32  instruction in IF/ID
- IFID_VALID  out  1  IF/ID holds a real instruction
- FETCH_STALL  out  1  fetch is waiting on memory (for hazard/debug)

Behaviour:
- States: BOOT, FETCH, WAIT, DISCARD.
- Async RESET forces the following. Outputs then hold until the first CLOCK edge after RESET deasserts.
  - state=BOOT, IFID_PC=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0.
  - IMEM_READ=0, req_addr=RESET_VECTOR.
- BOOT:
  - NEXTPC=RESET_VECTOR and IMEM_READ=0.
  - Next edge goes to FETCH, so the PC register holds RESET_VECTOR from cycle 1.
- FETCH/WAIT:
  - IMEM_READ=1 and IMEM_ADDR=req_addr.
  - In FETCH, req_addr is combinationally PC. It is registered on entry to WAIT, so the address stays stable while busy even if PC changes.
- NEXTPC priority, combinational, must settle before the CLOCK edge:
  1. state BOOT → RESET_VECTOR
  2. BRANCH_TAKEN → BRANCH_TARGET
  3. HAZARD_STALL, or fetch not completing this cycle (IMEM_BUSYWAIT=1, or state DISCARD) → PC (hold)
  4. otherwise → PC+4, modulo 2^XLEN (0xFFFF_FFFC+4 wraps to 0)
- Transitions:
  - FETCH with IMEM_BUSYWAIT=1 → WAIT.
  - WAIT with IMEM_BUSYWAIT=0 → FETCH.
  - BRANCH_TAKEN while state is WAIT, or FETCH with IMEM_BUSYWAIT=1 → DISCARD. The in-flight read is to a stale address.
  - In DISCARD, IMEM_READ stays 1 at the old req_addr until IMEM_BUSYWAIT=0. The returned data is dropped, then the state goes to FETCH at the PC already redirected.
  - BRANCH_TAKEN arriving in DISCARD → stay in DISCARD; the newest target wins via NEXTPC.
- IF/ID update per edge, priority order:
  1. BRANCH_TAKEN → flush: IFID_VALID=0, IFID_INSTR=NOP_INSTR.
  2. HAZARD_STALL → hold all IF/ID fields.
  3. Fetch completes (FETCH/WAIT, IMEM_BUSYWAIT=0) → IFID_PC=req_addr, IFID_INSTR=IMEM_INSTR, IFID_VALID=1.
  4. Otherwise → bubble: IFID_VALID=0, IFID_INSTR=NOP_INSTR, IFID_PC holds.
- HAZARD_STALL together with a completed fetch:
  - The returned word is not buffered. PC is held, so the same address is re-fetched next cycle.
  - Single-cycle memory therefore costs no extra cycles.
- FETCH_STALL = (state==WAIT) | (state==DISCARD) | (IMEM_READ & IMEM_BUSYWAIT).
- Misaligned BRANCH_TARGET: bits [1:0] are forced to 0 on NEXTPC. There is no exception path in this block.
- RESET asserted mid-transaction: the read is abandoned immediately (IMEM_READ=0). The memory model must tolerate an aborted read.

Decomposition:
- Shared package rv32_pkg holds NOP_INSTR, RESET_VECTOR, XLEN, and the fetch_state_t enum {BOOT, FETCH, WAIT, DISCARD}.
- One sub-module, if_id_reg: the IF/ID register with flush/stall/load controls and async RESET to NOP.
- The FSM and NEXTPC mux stay in if_fetch_stage.

Test Plan:
1. Reset, zero-wait memory returning addr-tagged words:
   - Cycle 0: NEXTPC=0.
   - Then IFID_PC 0,4,8,… one per cycle, IFID_VALID=1 from the second edge.
2. IMEM_BUSYWAIT high 3 cycles on address 0x8:
   - PC holds 0x8, FETCH_STALL=1, IFID_VALID=0 for 3 cycles.
   - Then IFID_PC=0x8 and the correct instruction.
3. BRANCH_TAKEN with target 0x100 while fetching 0x10 with zero-wait memory:
   - IFID flushed to NOP/VALID=0.
   - Next IFID_PC=0x100; 0x14 never appears.
4. BRANCH_TAKEN to 0x200 during WAIT on 0x20 (busy 2 more cycles):
   - DISCARD is entered and IMEM_ADDR stays 0x20 until done.
   - 0x20 data is dropped, and the next valid IFID_PC=0x200.
5. HAZARD_STALL for 2 cycles at PC=0x40:
   - IFID contents held.
   - PC held at 0x40, then resumes 0x40→0x44 with no skipped or duplicated IFID_PC.
6. Wrap and reset:
   - BRANCH_TARGET=0xFFFF_FFFC → next NEXTPC=0x0.
   - RESET asserted while in WAIT → IMEM_READ=0 and IFID_INSTR=0x13 immediately (asynchronous).
